// File: rtl/axi_mem_master.sv
// axi_mem_master
// Bridges a simple core memory request (one read burst or one single-beat
// write) onto AXI4. Only one transaction is in flight at a time.
//
// Ports
//   ACLK, ARESETn        clock (rising edge), async active-low reset
//   c_req/c_we/c_addr/c_wdata/c_wstrb   core request, held until c_ready
//   c_ready              request accepted when c_req & c_ready
//   c_rvalid/c_rdata/c_rlast            read beats returned to the core
//   c_done/c_err         one-cycle completion pulse and its error status
//   AR/R/AW/W/B          AXI4 master channels
//   dbg_state            current FSM state, for observation only
//
// Handshake semantics (all AXI channels): a transfer happens on a rising
// edge where VALID & READY are both high. Every VALID driven here is decoded
// from registered state only, so it never depends on READY, and once raised
// it stays high with a stable payload until its READY is seen.
module axi_mem_master #(
  parameter int              ID_W = 4,
  parameter logic [ID_W-1:0] MID  = '0,
  parameter logic [3:0]      RLEN = 4'd0
) (
  input  logic            ACLK,
  input  logic            ARESETn,
  input  logic            c_req,
  input  logic            c_we,
  input  logic [31:0]     c_addr,
  input  logic [31:0]     c_wdata,
  input  logic [3:0]      c_wstrb,
  output logic            c_ready,
  output logic            c_rvalid,
  output logic [31:0]     c_rdata,
  output logic            c_rlast,
  output logic            c_done,
  output logic            c_err,
  output logic [ID_W-1:0] ARID,
  output logic [31:0]     ARADDR,
  output logic [3:0]      ARLEN,
  output logic [2:0]      ARSIZE,
  output logic [1:0]      ARBURST,
  output logic            ARVALID,
  input  logic            ARREADY,
  input  logic [ID_W-1:0] RID,
  input  logic [31:0]     RDATA,
  input  logic [1:0]      RRESP,
  input  logic            RLAST,
  input  logic            RVALID,
  output logic            RREADY,
  output logic [ID_W-1:0] AWID,
  output logic [31:0]     AWADDR,
  output logic [3:0]      AWLEN,
  output logic [2:0]      AWSIZE,
  output logic [1:0]      AWBURST,
  output logic            AWVALID,
  input  logic            AWREADY,
  output logic [31:0]     WDATA,
  output logic [3:0]      WSTRB,
  output logic            WLAST,
  output logic            WVALID,
  input  logic            WREADY,
  input  logic [ID_W-1:0] BID,
  input  logic [1:0]      BRESP,
  input  logic            BVALID,
  output logic            BREADY,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WRITE = 3'd3,
    ST_WRESP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        err_q;
  logic [3:0]  beat_cnt;
  logic        aw_done;
  logic        w_done;
  logic        done_q;

  logic accept;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic cnt_hit;
  logic r_end;

  // IDs are not checked; keep them visibly consumed.
  logic unused_ids;
  assign unused_ids = ^{RID, BID};

  // Static AXI fields.
  assign ARID    = MID;
  assign AWID    = MID;
  assign ARLEN   = RLEN;
  assign AWLEN   = 4'd0;
  assign ARSIZE  = 3'b010;
  assign AWSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign AWBURST = 2'b01;
  assign WLAST   = 1'b1;

  assign ARADDR = addr_q;
  assign AWADDR = addr_q;
  assign WDATA  = wdata_q;
  assign WSTRB  = wstrb_q;

  assign accept = c_req & (state_q == ST_IDLE);
  assign ar_hs  = ARVALID & ARREADY;
  assign r_hs   = RREADY & RVALID;
  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;
  assign b_hs   = BREADY & BVALID;

  // The burst ends on whichever comes first: RLAST from the slave or the
  // local beat count reaching the programmed length.
  assign cnt_hit = (beat_cnt == RLEN);
  assign r_end   = r_hs & (RLAST | cnt_hit);

  assign c_done    = done_q;
  assign c_err     = done_q & err_q;
  assign dbg_state = state_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      err_q    <= 1'b0;
      beat_cnt <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= r_end | b_hs;
      if (accept) begin
        addr_q   <= c_addr;
        wdata_q  <= c_wdata;
        wstrb_q  <= c_wstrb;
        err_q    <= 1'b0;
        beat_cnt <= '0;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end
      if (r_hs) begin
        beat_cnt <= beat_cnt + 4'd1;
        // A bad response or a length disagreement both flag the burst.
        if ((RRESP != 2'b00) || (RLAST != cnt_hit)) begin
          err_q <= 1'b1;
        end
      end
      if (aw_hs) begin
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        w_done <= 1'b1;
      end
      if (b_hs && (BRESP != 2'b00)) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    c_ready  = 1'b0;
    ARVALID  = 1'b0;
    RREADY   = 1'b0;
    AWVALID  = 1'b0;
    WVALID   = 1'b0;
    BREADY   = 1'b0;
    c_rvalid = 1'b0;
    c_rdata  = '0;
    c_rlast  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        c_ready = 1'b1;
        if (c_req) begin
          state_d = c_we ? ST_WRITE : ST_RADDR;
        end
      end
      ST_RADDR: begin
        ARVALID = 1'b1;
        if (ar_hs) begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        RREADY   = 1'b1;
        c_rvalid = RVALID;
        c_rdata  = RVALID ? RDATA : '0;
        c_rlast  = RVALID & RLAST;
        if (r_end) begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        AWVALID = ~aw_done;
        WVALID  = ~w_done;
        // Either channel may complete first, or both in the same cycle.
        if ((aw_done | aw_hs) && (w_done | w_hs)) begin
          state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        BREADY = 1'b1;
        if (b_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
